// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared MIPS opcode constants, field slices and forward-select encodings
package mips_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  localparam int OP_HI = 31;
  localparam int OP_LO = 26;
  localparam int RS_HI = 25;
  localparam int RS_LO = 21;
  localparam int RT_HI = 20;
  localparam int RT_LO = 16;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_LB    = 6'h20;
  localparam logic [5:0] OP_LH    = 6'h21;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_LBU   = 6'h24;
  localparam logic [5:0] OP_LHU   = 6'h25;
  localparam logic [5:0] OP_SB    = 6'h28;
  localparam logic [5:0] OP_SH    = 6'h29;
  localparam logic [5:0] OP_SW    = 6'h2B;

  typedef enum logic [1:0] {
    FWD_REG   = 2'd0,
    FWD_EXMEM = 2'd1,
    FWD_MEMWB = 2'd2
  } fwd_sel_t;

  function automatic logic is_load(input logic [5:0] op);
    return (op == OP_LB) || (op == OP_LH) || (op == OP_LW) ||
           (op == OP_LBU) || (op == OP_LHU);
  endfunction

  // Opcodes that read rt as a source (R-type, branches, stores).
  function automatic logic uses_rt(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_BEQ) || (op == OP_BNE) ||
           (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
  endfunction

endpackage

// File: rtl/id_ex_stage_if.sv
// rtl/id_ex_stage_if.sv - ID-side, bypass and EXE-side signals of the ID/EX stage
interface id_ex_stage_if #(
  parameter int DATA_W = 32,
  parameter int PC_W   = 32,
  parameter int CNT_W  = 16
);
  logic [31:0]       instr_id;
  logic [PC_W-1:0]   pc_id;
  logic [DATA_W-1:0] a_id;
  logic [DATA_W-1:0] b_id;
  logic              flush;
  logic              hold;
  logic              ex_mem_reg_write;
  logic [4:0]        ex_mem_num_write;
  logic [DATA_W-1:0] ex_mem_result;
  logic              mem_wb_reg_write;
  logic [4:0]        mem_wb_num_write;
  logic [DATA_W-1:0] mem_wb_data;

  logic              stall;
  logic [31:0]       instr_ex;
  logic [PC_W-1:0]   pc_ex;
  logic              valid_ex;
  logic [DATA_W-1:0] a_ex;
  logic [DATA_W-1:0] b_ex;
  logic [1:0]        fwd_a;
  logic [1:0]        fwd_b;
  logic [CNT_W-1:0]  bubble_cnt;

  modport master (
    output instr_id, pc_id, a_id, b_id, flush, hold,
           ex_mem_reg_write, ex_mem_num_write, ex_mem_result,
           mem_wb_reg_write, mem_wb_num_write, mem_wb_data,
    input  stall, instr_ex, pc_ex, valid_ex, a_ex, b_ex, fwd_a, fwd_b, bubble_cnt
  );

  modport slave (
    input  instr_id, pc_id, a_id, b_id, flush, hold,
           ex_mem_reg_write, ex_mem_num_write, ex_mem_result,
           mem_wb_reg_write, mem_wb_num_write, mem_wb_data,
    output stall, instr_ex, pc_ex, valid_ex, a_ex, b_ex, fwd_a, fwd_b, bubble_cnt
  );
endinterface

// File: rtl/fwd_mux.sv
// rtl/fwd_mux.sv - per-operand bypass selector, EX/MEM over MEM/WB over stored value
module fwd_mux
  import mips_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [4:0]        src,
  input  logic              ex_mem_en,
  input  logic [4:0]        ex_mem_num,
  input  logic [DATA_W-1:0] ex_mem_data,
  input  logic              mem_wb_en,
  input  logic [4:0]        mem_wb_num,
  input  logic [DATA_W-1:0] mem_wb_data,
  input  logic [DATA_W-1:0] stored,
  output logic [DATA_W-1:0] operand,
  output logic [1:0]        sel
);

  // Pick the youngest producer of src; $0 is hardwired and never bypassed.
  always_comb begin
    operand = stored;
    sel     = FWD_REG;
    if (src != 5'd0) begin
      if (ex_mem_en && (ex_mem_num == src)) begin
        operand = ex_mem_data;
        sel     = FWD_EXMEM;
      end else if (mem_wb_en && (mem_wb_num == src)) begin
        operand = mem_wb_data;
        sel     = FWD_MEMWB;
      end
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX pipeline register with forwarding, load-use stall and bubble counter
module id_ex_stage
  import mips_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int PC_W   = 32,
  parameter int CNT_W  = 16
) (
  input  logic        clock,
  input  logic        reset,
  id_ex_stage_if.slave bus
);

  logic [31:0]       instr_q;
  logic [PC_W-1:0]   pc_q;
  logic              valid_q;
  logic [DATA_W-1:0] a_q;
  logic [DATA_W-1:0] b_q;
  logic [CNT_W-1:0]  cnt_q;

  logic [4:0] rs_id, rt_id, rs_ex, rt_ex;
  logic [5:0] op_id, op_ex;
  logic       load_use;
  logic [DATA_W-1:0] a_cap, b_cap;
  logic [1:0] unused_wb_sel_a, unused_wb_sel_b;

  assign rs_id = bus.instr_id[RS_HI:RS_LO];
  assign rt_id = bus.instr_id[RT_HI:RT_LO];
  assign op_id = bus.instr_id[OP_HI:OP_LO];
  assign rs_ex = instr_q[RS_HI:RS_LO];
  assign rt_ex = instr_q[RT_HI:RT_LO];
  assign op_ex = instr_q[OP_HI:OP_LO];

  assign load_use = valid_q && is_load(op_ex) && (rt_ex != 5'd0) &&
                    ((rt_ex == rs_id) || (uses_rt(op_id) && (rt_ex == rt_id)));

  // A flush discards the dependent instruction, so the load-use stall is moot then.
  assign bus.stall = bus.hold | (load_use & ~bus.flush);

  // The register file writes on the same posedge we capture, so bypass WB here.
  fwd_mux #(.DATA_W(DATA_W)) u_wb_a (
    .src(rs_id), .ex_mem_en(1'b0), .ex_mem_num(5'd0), .ex_mem_data('0),
    .mem_wb_en(bus.mem_wb_reg_write), .mem_wb_num(bus.mem_wb_num_write),
    .mem_wb_data(bus.mem_wb_data), .stored(bus.a_id),
    .operand(a_cap), .sel(unused_wb_sel_a)
  );

  fwd_mux #(.DATA_W(DATA_W)) u_wb_b (
    .src(rt_id), .ex_mem_en(1'b0), .ex_mem_num(5'd0), .ex_mem_data('0),
    .mem_wb_en(bus.mem_wb_reg_write), .mem_wb_num(bus.mem_wb_num_write),
    .mem_wb_data(bus.mem_wb_data), .stored(bus.b_id),
    .operand(b_cap), .sel(unused_wb_sel_b)
  );

  // Pipeline register update: reset > flush > hold > load-use bubble > capture.
  always_ff @(posedge clock) begin
    if (reset) begin
      instr_q <= NOP_INSTR;
      pc_q    <= '0;
      valid_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      cnt_q   <= '0;
    end else if (bus.flush) begin
      instr_q <= NOP_INSTR;
      valid_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
    end else if (bus.hold) begin
      instr_q <= instr_q;
    end else if (load_use) begin
      instr_q <= NOP_INSTR;
      valid_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      if (cnt_q != '1) cnt_q <= cnt_q + CNT_W'(1);
    end else begin
      instr_q <= bus.instr_id;
      pc_q    <= bus.pc_id;
      valid_q <= 1'b1;
      a_q     <= a_cap;
      b_q     <= b_cap;
    end
  end

  fwd_mux #(.DATA_W(DATA_W)) u_fwd_a (
    .src(rs_ex),
    .ex_mem_en(bus.ex_mem_reg_write), .ex_mem_num(bus.ex_mem_num_write),
    .ex_mem_data(bus.ex_mem_result),
    .mem_wb_en(bus.mem_wb_reg_write), .mem_wb_num(bus.mem_wb_num_write),
    .mem_wb_data(bus.mem_wb_data), .stored(a_q),
    .operand(bus.a_ex), .sel(bus.fwd_a)
  );

  fwd_mux #(.DATA_W(DATA_W)) u_fwd_b (
    .src(rt_ex),
    .ex_mem_en(bus.ex_mem_reg_write), .ex_mem_num(bus.ex_mem_num_write),
    .ex_mem_data(bus.ex_mem_result),
    .mem_wb_en(bus.mem_wb_reg_write), .mem_wb_num(bus.mem_wb_num_write),
    .mem_wb_data(bus.mem_wb_data), .stored(b_q),
    .operand(bus.b_ex), .sel(bus.fwd_b)
  );

  assign bus.instr_ex   = instr_q;
  assign bus.pc_ex      = pc_q;
  assign bus.valid_ex   = valid_q;
  assign bus.bubble_cnt = cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// tb/tb_id_ex_stage.sv - directed self-checking bench for id_ex_stage
module tb_id_ex_stage;

  logic clock;
  logic reset;
  int checks;
  int failures;

  id_ex_stage_if #(.DATA_W(32), .PC_W(32), .CNT_W(4)) bus ();

  id_ex_stage #(.DATA_W(32), .PC_W(32), .CNT_W(4)) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [31:0] r_type(input logic [4:0] rs, input logic [4:0] rt,
                                         input logic [4:0] rd, input logic [5:0] funct);
    return {6'h00, rs, rt, rd, 5'd0, funct};
  endfunction

  function automatic logic [31:0] i_type(input logic [5:0] op, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_bypass();
    bus.ex_mem_reg_write = 1'b0;
    bus.ex_mem_num_write = 5'd0;
    bus.ex_mem_result    = 32'h0;
    bus.mem_wb_reg_write = 1'b0;
    bus.mem_wb_num_write = 5'd0;
    bus.mem_wb_data      = 32'h0;
  endtask

  logic [31:0] add_3_1_2, sub_4_3_5, lw_2_1, add_5_2_2, addi_2_1, add_8_7_0, add_8_0_0;

  initial begin
    checks   = 0;
    failures = 0;
    add_3_1_2 = r_type(5'd1, 5'd2, 5'd3, 6'h20);
    sub_4_3_5 = r_type(5'd3, 5'd5, 5'd4, 6'h22);
    lw_2_1    = i_type(6'h23, 5'd1, 5'd2, 16'h0000);
    add_5_2_2 = r_type(5'd2, 5'd2, 5'd5, 6'h20);
    addi_2_1  = i_type(6'h08, 5'd1, 5'd2, 16'h0004);
    add_8_7_0 = r_type(5'd7, 5'd0, 5'd8, 6'h20);
    add_8_0_0 = r_type(5'd0, 5'd0, 5'd8, 6'h20);

    reset = 1'b1;
    bus.instr_id = 32'h0;
    bus.pc_id = 32'h0;
    bus.a_id = 32'h0;
    bus.b_id = 32'h0;
    bus.flush = 1'b0;
    bus.hold = 1'b0;
    clear_bypass();
    tick();
    tick();
    reset = 1'b0;
    #1;
    check("rst_valid", 64'(bus.valid_ex), 64'd0);
    check("rst_instr", 64'(bus.instr_ex), 64'h0);
    check("rst_pc", 64'(bus.pc_ex), 64'h0);
    check("rst_cnt", 64'(bus.bubble_cnt), 64'h0);
    check("rst_stall", 64'(bus.stall), 64'd0);
    check("rst_fwd_a", 64'(bus.fwd_a), 64'd0);

    // Forwarding into EXE.
    bus.instr_id = add_3_1_2; bus.pc_id = 32'h100; bus.a_id = 32'h5; bus.b_id = 32'h6;
    tick();
    check("cap_valid", 64'(bus.valid_ex), 64'd1);
    check("cap_pc", 64'(bus.pc_ex), 64'h100);
    check("cap_a", 64'(bus.a_ex), 64'h5);
    check("cap_b", 64'(bus.b_ex), 64'h6);
    bus.instr_id = sub_4_3_5; bus.pc_id = 32'h104; bus.a_id = 32'h99; bus.b_id = 32'h7;
    tick();
    bus.ex_mem_reg_write = 1'b1; bus.ex_mem_num_write = 5'd3; bus.ex_mem_result = 32'h11;
    #1;
    check("exmem_a", 64'(bus.a_ex), 64'h11);
    check("exmem_fwd_a", 64'(bus.fwd_a), 64'd1);
    check("exmem_b_reg", 64'(bus.b_ex), 64'h7);
    bus.mem_wb_reg_write = 1'b1; bus.mem_wb_num_write = 5'd3; bus.mem_wb_data = 32'h22;
    #1;
    check("dual_a", 64'(bus.a_ex), 64'h11);
    check("dual_fwd_a", 64'(bus.fwd_a), 64'd1);
    bus.ex_mem_reg_write = 1'b0;
    #1;
    check("memwb_a", 64'(bus.a_ex), 64'h22);
    check("memwb_fwd_a", 64'(bus.fwd_a), 64'd2);
    bus.mem_wb_reg_write = 1'b0;
    bus.ex_mem_reg_write = 1'b1; bus.ex_mem_num_write = 5'd5; bus.ex_mem_result = 32'h33;
    #1;
    check("exmem_b", 64'(bus.b_ex), 64'h33);
    check("exmem_fwd_b", 64'(bus.fwd_b), 64'd1);
    check("stored_a", 64'(bus.a_ex), 64'h99);
    clear_bypass();

    // Load-use: one bubble, then the dependent add.
    bus.instr_id = lw_2_1; bus.pc_id = 32'h108; bus.a_id = 32'h40; bus.b_id = 32'h0;
    tick();
    bus.instr_id = addi_2_1; bus.pc_id = 32'h10C;
    #1;
    check("addi_no_stall", 64'(bus.stall), 64'd0);
    bus.instr_id = add_5_2_2;
    #1;
    check("lu_stall", 64'(bus.stall), 64'd1);
    tick();
    check("lu_bubble_valid", 64'(bus.valid_ex), 64'd0);
    check("lu_bubble_instr", 64'(bus.instr_ex), 64'h0);
    check("lu_cnt", 64'(bus.bubble_cnt), 64'd1);
    check("lu_stall_clear", 64'(bus.stall), 64'd0);
    tick();
    check("lu_add_valid", 64'(bus.valid_ex), 64'd1);
    check("lu_add_instr", 64'(bus.instr_ex), 64'(add_5_2_2));

    // WB bypass at capture.
    bus.instr_id = add_8_7_0; bus.a_id = 32'h0; bus.b_id = 32'h0;
    bus.mem_wb_reg_write = 1'b1; bus.mem_wb_num_write = 5'd7; bus.mem_wb_data = 32'hABCD;
    tick();
    clear_bypass();
    #1;
    check("wb_cap_a", 64'(bus.a_ex), 64'hABCD);
    check("wb_cap_fwd", 64'(bus.fwd_a), 64'd0);
    bus.instr_id = add_8_0_0; bus.a_id = 32'h55;
    bus.mem_wb_reg_write = 1'b1; bus.mem_wb_num_write = 5'd0; bus.mem_wb_data = 32'hABCD;
    tick();
    clear_bypass();
    #1;
    check("wb_r0_a", 64'(bus.a_ex), 64'h55);

    // Flush with load-use, hold, flush with hold.
    bus.instr_id = lw_2_1; bus.a_id = 32'h0;
    tick();
    bus.instr_id = add_5_2_2; bus.flush = 1'b1;
    #1;
    check("flush_lu_stall", 64'(bus.stall), 64'd0);
    tick();
    check("flush_valid", 64'(bus.valid_ex), 64'd0);
    check("flush_instr", 64'(bus.instr_ex), 64'h0);
    check("flush_cnt", 64'(bus.bubble_cnt), 64'd1);
    bus.flush = 1'b0;
    bus.instr_id = add_3_1_2; bus.pc_id = 32'h200;
    tick();
    check("pre_hold_pc", 64'(bus.pc_ex), 64'h200);
    bus.hold = 1'b1; bus.instr_id = sub_4_3_5; bus.pc_id = 32'h204;
    #1;
    check("hold_stall", 64'(bus.stall), 64'd1);
    tick();
    check("hold_instr", 64'(bus.instr_ex), 64'(add_3_1_2));
    check("hold_pc", 64'(bus.pc_ex), 64'h200);
    check("hold_valid", 64'(bus.valid_ex), 64'd1);
    bus.flush = 1'b1;
    tick();
    check("flush_hold_valid", 64'(bus.valid_ex), 64'd0);
    check("flush_hold_instr", 64'(bus.instr_ex), 64'h0);
    bus.flush = 1'b0; bus.hold = 1'b0;

    // Reset mid-run while hold is asserted.
    bus.instr_id = add_3_1_2; bus.pc_id = 32'h300;
    tick();
    check("pre_rst_valid", 64'(bus.valid_ex), 64'd1);
    reset = 1'b1; bus.hold = 1'b1;
    tick();
    reset = 1'b0; bus.hold = 1'b0;
    #1;
    check("mid_rst_valid", 64'(bus.valid_ex), 64'd0);
    check("mid_rst_instr", 64'(bus.instr_ex), 64'h0);
    check("mid_rst_cnt", 64'(bus.bubble_cnt), 64'd0);
    check("mid_rst_stall", 64'(bus.stall), 64'd0);

    // Saturation of the 4-bit bubble counter.
    for (int i = 1; i <= 16; i++) begin
      bus.instr_id = lw_2_1;
      tick();
      bus.instr_id = add_5_2_2;
      tick();
      if (i == 1)  check("sat_cnt_1", 64'(bus.bubble_cnt), 64'd1);
      if (i == 15) check("sat_cnt_15", 64'(bus.bubble_cnt), 64'hF);
      if (i == 16) check("sat_cnt_16", 64'(bus.bubble_cnt), 64'hF);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
